cost_batch_controller: RTL



---
 rtl/cost_pkg.sv | 22 ++
 rtl/label_onehot_decoder.sv | 21 ++
 rtl/cost_batch_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cost_pkg.sv
// Shared types and constants for the cost-calculation batch controller.
package cost_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int CONF_W     = 4;
    localparam int COST_W     = 8;
    localparam int LABEL_W    = 4;

    typedef logic [0:NUM_DIGITS-1][CONF_W-1:0] weights_t;
    typedef logic [0:NUM_DIGITS-1]             onehot_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_ACC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/label_onehot_decoder.sv
// Label index to one-hot digit vector; out-of-range labels give an all-zero vector.
module label_onehot_decoder
    import cost_pkg::*;
(
    input  logic [LABEL_W-1:0] label,
    output onehot_t            onehot,
    output logic               invalid
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        onehot  = '0;
        invalid = (label >= LABEL_W'(NUM_DIGITS));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (label == LABEL_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cost_batch_controller.sv
// Initiator for the cost calculator: feeds labelled samples, accumulates per-sample
// costs over a batch and reports saturating total, mean and max.
module cost_batch_controller
    import cost_pkg::*;
#(
    parameter int LOG2_BATCH = 3,
    parameter int ACC_W      = 16,
    parameter int TIMEOUT    = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 batch_start,
    input  logic                 sample_valid,
    input  logic [LABEL_W-1:0]   sample_label,
    input  weights_t             sample_weights,
    output logic                 sample_ready,
    output logic                 cost_en,
    output onehot_t              expected_label,
    output weights_t             digit_weights,
    input  logic                 calculation_complete,
    input  logic [COST_W-1:0]    cost_output,
    output logic [ACC_W-1:0]     batch_total,
    output logic [COST_W-1:0]    batch_mean,
    output logic [COST_W-1:0]    batch_max,
    output logic                 batch_done,
    output logic                 busy,
    output logic                 err_label,
    output logic                 err_timeout
);

    localparam int CNT_W      = LOG2_BATCH + 1;
    localparam int WD_W       = $clog2(TIMEOUT + 1) + 1;
    localparam int ARM_CYCLES = 2;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_BATCH) - 1);

    state_t              state;
    logic [CNT_W-1:0]    sample_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic [ACC_W-1:0]    acc_total;
    logic [COST_W-1:0]   acc_max;
    logic [COST_W-1:0]   sample_cost;

    onehot_t             dec_onehot;
    logic                dec_invalid;

    logic [ACC_W:0]      sum_wide;
    logic [ACC_W-1:0]    total_next;
    logic [ACC_W-1:0]    mean_shift;
    logic [COST_W-1:0]   mean_next;
    logic [COST_W-1:0]   max_next;

    label_onehot_decoder u_decoder (
        .label   (sample_label),
        .onehot  (dec_onehot),
        .invalid (dec_invalid)
    );

    // The extra carry bit detects overflow so the total can clamp at all-ones.
    always_comb begin
        sum_wide   = {1'b0, acc_total} + (ACC_W + 1)'(sample_cost);
        total_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        mean_shift = total_next >> LOG2_BATCH;
        mean_next  = (mean_shift > ACC_W'(8'hFF)) ? '1 : mean_shift[COST_W-1:0];
        max_next   = (sample_cost > acc_max) ? sample_cost : acc_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sample_cnt     <= '0;
            wd_cnt         <= '0;
            acc_total      <= '0;
            acc_max        <= '0;
            sample_cost    <= '0;
            sample_ready   <= 1'b0;
            cost_en        <= 1'b0;
            expected_label <= '0;
            digit_weights  <= '0;
            batch_total    <= '0;
            batch_mean     <= '0;
            batch_max      <= '0;
            batch_done     <= 1'b0;
            busy           <= 1'b0;
            err_label      <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            cost_en    <= 1'b0;
            batch_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (batch_start) begin
                        sample_cnt   <= '0;
                        acc_total    <= '0;
                        acc_max      <= '0;
                        err_label    <= 1'b0;
                        err_timeout  <= 1'b0;
                        busy         <= 1'b1;
                        sample_ready <= 1'b1;
                        state        <= ST_GET;
                    end
                end

                ST_GET: begin
                    if (sample_valid) begin
                        digit_weights  <= sample_weights;
                        expected_label <= dec_onehot;
                        if (dec_invalid) begin
                            err_label <= 1'b1;
                        end
                        sample_ready <= 1'b0;
                        state        <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (calculation_complete) begin
                        cost_en <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= ST_ARM;
                    end
                end

                // Calculator must leave idle within two cycles of the request.
                ST_ARM: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (!calculation_complete) begin
                        state <= ST_WAIT;
                    end else if (wd_cnt == WD_W'(ARM_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        sample_cost <= '0;
                        state       <= ST_ACC;
                    end
                end

                ST_WAIT: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (calculation_complete) begin
                        sample_cost <= cost_output;
                        state       <= ST_ACC;
                    end else if (wd_cnt >= WD_W'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        sample_cost <= '0;
                        state       <= ST_ACC;
                    end
                end

                ST_ACC: begin
                    acc_total  <= total_next;
                    acc_max    <= max_next;
                    sample_cnt <= sample_cnt + CNT_W'(1);
                    if (sample_cnt == LAST_SAMPLE) begin
                        batch_total <= total_next;
                        batch_mean  <= mean_next;
                        batch_max   <= max_next;
                        batch_done  <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        sample_ready <= 1'b1;
                        state        <= ST_GET;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
